// File: rtl/ne_pkg.sv
// Shared state type and default widths for the ne datapath blocks:
// load controller, result store unit and SDRAM controller.
package ne_pkg;

   localparam int NE_DATA_W       = 16;
   localparam int NE_SDRAM_ADDR_W = 24;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CAP  = 3'd2,
      ST_WR   = 3'd3,
      ST_DONE = 3'd4
   } store_state_t;

endpackage

// File: rtl/result_store_unit.sv
// Writeback engine: streams STORE_DEPTH words from local result memory to SDRAM
// through a req/ack write handshake, then pulses store_done.
module result_store_unit
   import ne_pkg::*;
#(
   parameter int                        STORE_DEPTH  = 256,
   parameter int                        ADDR_W       = 10,
   parameter int                        DATA_W       = NE_DATA_W,
   parameter int                        SDRAM_ADDR_W = NE_SDRAM_ADDR_W,
   parameter logic [SDRAM_ADDR_W-1:0]   SDRAM_BASE   = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   output logic                    mem_rd_en,
   output logic [ADDR_W-1:0]       mem_address,
   input  logic [DATA_W-1:0]       mem_dout,
   output logic                    sdram_wr_req,
   output logic [SDRAM_ADDR_W-1:0] sdram_wr_addr,
   output logic [DATA_W-1:0]       sdram_din,
   input  logic                    sdram_wr_ack,
   output logic                    busy,
   output logic                    store_done,
   output logic [ADDR_W:0]         word_count
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(STORE_DEPTH - 1);
   localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

   store_state_t              state_q, state_d;
   logic [ADDR_W-1:0]         idx_q, idx_d;
   logic [DATA_W-1:0]         data_q, data_d;
   logic [SDRAM_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [ADDR_W:0]           count_q, count_d;

   always_comb begin
      // NOTE: every next-state signal gets its hold value first, so no path through
      // the case statement can leave one unassigned and infer a latch.
      state_d   = state_q;
      idx_d     = idx_q;
      data_d    = data_q;
      wr_addr_d = wr_addr_q;
      count_d   = count_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               idx_d   = '0;
               count_d = '0;
               state_d = ST_RD;
            end
         end
         ST_RD:   state_d = ST_CAP;
         ST_CAP: begin
            // Address is latched with the data so both stay frozen across ack wait states.
            data_d    = mem_dout;
            wr_addr_d = SDRAM_BASE + SDRAM_ADDR_W'(idx_q);
            state_d   = ST_WR;
         end
         ST_WR: begin
            if (sdram_wr_ack) begin
               count_d = count_q + CNT_ONE;
               if (idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + IDX_ONE;
                  state_d = ST_RD;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, regardless of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         data_q    <= '0;
         wr_addr_q <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         wr_addr_q <= wr_addr_d;
         count_q   <= count_d;
      end
   end

   assign mem_rd_en     = (state_q == ST_RD);
   assign mem_address   = idx_q;
   assign sdram_wr_req  = (state_q == ST_WR);
   assign sdram_wr_addr = wr_addr_q;
   assign sdram_din     = data_q;
   assign busy          = (state_q != ST_IDLE);
   assign store_done    = (state_q == ST_DONE);
   assign word_count    = count_q;

endmodule

// File: tb/tb_result_store_unit.sv
// Randomized bench for result_store_unit: two instances (plain base and wrapping base)
// checked cycle by cycle against a per-word request schedule derived from ack delays.
module tb_result_store_unit;

   localparam int DEPTH = 4;
   localparam int AW    = 2;
   localparam int DW    = 16;
   localparam int SW    = 24;
   localparam logic [SW-1:0] BASE_A = 24'h000100;
   localparam logic [SW-1:0] BASE_B = 24'hFFFFFE;

   logic clk, reset, start, ack;

   logic          a_rd_en, a_req, a_busy, a_done;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_dout, a_din;
   logic [SW-1:0] a_waddr;
   logic [AW:0]   a_wc;

   logic          b_rd_en, b_req, b_busy, b_done;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_dout, b_din;
   logic [SW-1:0] b_waddr;
   logic [AW:0]   b_wc;

   logic [DW-1:0] mem [DEPTH];
   int checks = 0;
   int errors = 0;
   int dly [DEPTH];
   int s   [DEPTH];

   result_store_unit #(.STORE_DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW),
                       .SDRAM_ADDR_W(SW), .SDRAM_BASE(BASE_A)) dut_a (
      .clk(clk), .reset(reset), .start(start),
      .mem_rd_en(a_rd_en), .mem_address(a_addr), .mem_dout(a_dout),
      .sdram_wr_req(a_req), .sdram_wr_addr(a_waddr), .sdram_din(a_din),
      .sdram_wr_ack(ack), .busy(a_busy), .store_done(a_done), .word_count(a_wc));

   result_store_unit #(.STORE_DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW),
                       .SDRAM_ADDR_W(SW), .SDRAM_BASE(BASE_B)) dut_b (
      .clk(clk), .reset(reset), .start(start),
      .mem_rd_en(b_rd_en), .mem_address(b_addr), .mem_dout(b_dout),
      .sdram_wr_req(b_req), .sdram_wr_addr(b_waddr), .sdram_din(b_din),
      .sdram_wr_ack(ack), .busy(b_busy), .store_done(b_done), .word_count(b_wc));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous-read memory; garbage on idle cycles, which the DUT must ignore.
   always @(posedge clk) begin
      a_dout <= a_rd_en ? mem[a_addr] : DW'($urandom);
      b_dout <= b_rd_en ? mem[b_addr] : DW'($urandom);
   end

   // One full pass, called at a negedge in ST_IDLE. abort_cyc > 0 asserts reset mid-pass.
   task automatic run_pass(input string tag, input bit poke_start, input int abort_cyc);
      int done_cyc, k_req, k_rd, exp_wc, last;
      logic [SW-1:0] ea, eb;
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      s[0] = 3;
      for (int i = 1; i < DEPTH; i++) s[i] = s[i-1] + dly[i-1] + 3;
      done_cyc = s[DEPTH-1] + dly[DEPTH-1] + 1;
      last     = (abort_cyc > 0) ? abort_cyc : done_cyc + 2;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= last; n++) begin
         k_req = -1; k_rd = -1; exp_wc = 0;
         for (int k = 0; k < DEPTH; k++) begin
            if (n >= s[k] && n <= s[k] + dly[k]) k_req = k;
            if (n == s[k] - 2) k_rd = k;
            if (s[k] + dly[k] < n) exp_wc++;
         end
         if (n == abort_cyc) begin
            #2 reset = 1'b1;
            #1;
            checks++;
            if ({a_req, a_rd_en, a_busy, a_done, a_wc, a_addr, a_waddr, a_din} !== '0 ||
                {b_req, b_rd_en, b_busy, b_done, b_wc, b_addr, b_waddr, b_din} !== '0) begin
               errors++;
               $display("FAIL %s async_reset n=%0d a_req=%b a_busy=%b a_wc=%0d a_waddr=%h a_din=%h b_waddr=%h exp all zero",
                        tag, n, a_req, a_busy, a_wc, a_waddr, a_din, b_waddr);
            end
            ack = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            return;
         end
         checks++;
         if (a_req !== (k_req >= 0) || b_req !== (k_req >= 0)) begin
            errors++;
            $display("FAIL %s req n=%0d got a=%b b=%b exp %b", tag, n, a_req, b_req, k_req >= 0);
         end
         if (k_req >= 0) begin
            ea = SW'((int'(BASE_A) + k_req) % (1 << SW));
            eb = SW'((int'(BASE_B) + k_req) % (1 << SW));
            checks++;
            if (a_waddr !== ea || b_waddr !== eb) begin
               errors++;
               $display("FAIL %s wr_addr n=%0d word %0d got a=%h b=%h exp a=%h b=%h",
                        tag, n, k_req, a_waddr, b_waddr, ea, eb);
            end
            checks++;
            if (a_din !== mem[k_req] || b_din !== mem[k_req]) begin
               errors++;
               $display("FAIL %s din n=%0d word %0d got a=%h b=%h exp %h",
                        tag, n, k_req, a_din, b_din, mem[k_req]);
            end
         end
         checks++;
         if (a_rd_en !== (k_rd >= 0) || (k_rd >= 0 && a_addr !== AW'(k_rd))) begin
            errors++;
            $display("FAIL %s mem_rd n=%0d got en=%b addr=%0d exp en=%b addr=%0d",
                     tag, n, a_rd_en, a_addr, k_rd >= 0, k_rd);
         end
         checks++;
         if (a_done !== (n == done_cyc) || b_done !== (n == done_cyc)) begin
            errors++;
            $display("FAIL %s store_done n=%0d got a=%b b=%b exp %b", tag, n, a_done, b_done, n == done_cyc);
         end
         checks++;
         if (a_busy !== (n <= done_cyc) || b_busy !== (n <= done_cyc)) begin
            errors++;
            $display("FAIL %s busy n=%0d got a=%b b=%b exp %b", tag, n, a_busy, b_busy, n <= done_cyc);
         end
         checks++;
         if (a_wc !== (AW+1)'(exp_wc) || b_wc !== (AW+1)'(exp_wc)) begin
            errors++;
            $display("FAIL %s word_count n=%0d got a=%0d b=%0d exp %0d", tag, n, a_wc, b_wc, exp_wc);
         end
         if (k_req >= 0) ack = (n == s[k_req] + dly[k_req]);
         else            ack = 1'($urandom_range(0, 1));
         start = poke_start && (k_req == 1 || n == done_cyc);
         @(posedge clk);
         @(negedge clk);
      end
      ack   = 1'b0;
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; ack = 1'b0;
      #1 reset = 1'b1;
      #2;
      checks++;
      if ({a_req, a_rd_en, a_busy, a_done, a_wc, a_addr, a_waddr, a_din} !== '0) begin
         errors++;
         $display("FAIL reset_values got req=%b busy=%b wc=%0d addr=%0d waddr=%h din=%h exp all zero",
                  a_req, a_busy, a_wc, a_addr, a_waddr, a_din);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset busy got a=%b b=%b exp 0", a_busy, b_busy);
      end
   endtask

   task automatic test_basic();
      for (int i = 0; i < DEPTH; i++) dly[i] = 0;
      run_pass("basic", 1'b0, 0);
   endtask

   task automatic test_wait_states();
      for (int i = 0; i < DEPTH; i++) dly[i] = 0;
      dly[1] = 5;
      run_pass("wait5", 1'b0, 0);
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < DEPTH; i++) dly[i] = $urandom_range(0, 4);
         run_pass("wait_rand", 1'b0, 0);
      end
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < DEPTH; i++) dly[i] = $urandom_range(0, 2);
         run_pass("start_ignored", 1'b1, 0);
      end
   endtask

   task automatic test_reset_midpass();
      for (int i = 0; i < DEPTH; i++) dly[i] = 0;
      dly[1] = 3;
      run_pass("reset_mid", 1'b0, 3 + 3 + 1);
      repeat (2) @(negedge clk);
      for (int i = 0; i < DEPTH; i++) dly[i] = $urandom_range(0, 3);
      run_pass("after_reset", 1'b0, 0);
   endtask

   task automatic test_start_held();
      bit seen;
      ack = 1'b1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int n = 1; n <= 15; n++) begin
         if (n == 13) begin
            checks++;
            if (a_done !== 1'b1) begin
               errors++;
               $display("FAIL held_start done n=%0d got %b exp 1", n, a_done);
            end
         end
         if (n == 14) begin
            checks++;
            if (a_busy !== 1'b0) begin
               errors++;
               $display("FAIL held_start idle n=%0d busy got %b exp 0", n, a_busy);
            end
         end
         if (n == 15) begin
            checks++;
            if (a_rd_en !== 1'b1 || a_addr !== '0 || a_wc !== '0) begin
               errors++;
               $display("FAIL held_start retrigger got rd_en=%b addr=%0d wc=%0d exp 1 0 0",
                        a_rd_en, a_addr, a_wc);
            end
            start = 1'b0;
         end
         if (n < 15) begin
            @(posedge clk);
            @(negedge clk);
         end
      end
      seen = 1'b0;
      for (int n = 0; n < 30 && !seen; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (a_done === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || a_wc !== (AW+1)'(DEPTH)) begin
         errors++;
         $display("FAIL held_start second_pass done_seen=%b wc=%0d exp 1 %0d", seen, a_wc, DEPTH);
      end
      ack = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wait_states();
      test_back_to_back();
      test_reset_midpass();
      test_start_held();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/result_store_unit.md
Name: result_store_unit

Overview:
Writeback engine: the opposite direction of the SDRAM-to-local-memory load path. Once started, it reads STORE_DEPTH words sequentially from the local result memory and writes each one to SDRAM through a req/ack write handshake toward the SDRAM controller. It then pulses store_done. It sits between the local memory read port and the SDRAM controller write port and is triggered by the top-level sequencer after the run phase.

Parameters:
STORE_DEPTH, 256, number of words to store; legal range 1..2**ADDR_W
ADDR_W, 10, local memory address width
DATA_W, 16, word width
SDRAM_ADDR_W, 24, SDRAM word-address width
SDRAM_BASE, 24'h000000, SDRAM word address of the first stored word

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a store pass; sampled only in ST_IDLE
mem_rd_en  out  1  local memory read strobe
mem_address  out  ADDR_W  local memory read address
mem_dout  in  DATA_W  local memory read data, valid the cycle after mem_rd_en
sdram_wr_req  out  1  write request to SDRAM controller
sdram_wr_addr  out  SDRAM_ADDR_W  SDRAM write word address
sdram_din  out  DATA_W  SDRAM write data
sdram_wr_ack  in  1  controller accepted current write
busy  out  1  high in every state except ST_IDLE
store_done  out  1  one-cycle pulse after the last word is acknowledged
word_count  out  ADDR_W+1  words acknowledged in current or last pass

Behaviour:
- Reset (async, any state): state=ST_IDLE, idx=0, data reg=0, word_count=0. All outputs are 0. An in-flight request is abandoned and sdram_wr_req drops immediately.
- States: ST_IDLE, ST_RD, ST_CAP, ST_WR, ST_DONE.
- ST_IDLE: start=1 sets idx=0 and word_count=0, then goes to ST_RD. start=0 stays in ST_IDLE.
- ST_RD (1 cycle): mem_rd_en=1, mem_address=idx. Next state is ST_CAP.
- ST_CAP (1 cycle): mem_dout is registered into the data reg at the end of this cycle. Next state is ST_WR.
- ST_WR: sdram_wr_req=1, sdram_wr_addr=SDRAM_BASE+idx, sdram_din=data reg.
  - All three outputs are held stable until sdram_wr_ack=1 is sampled.
  - ack may arrive in the first ST_WR cycle.
  - On ack, word_count increments. If idx==STORE_DEPTH-1, go to ST_DONE; otherwise idx increments and the state returns to ST_RD.
- ST_DONE (1 cycle): store_done=1. Next state is ST_IDLE.
- Timing: start is sampled at edge T. With zero-wait ack, word k's request is visible in cycle T+3k+3. store_done is high in cycle T+3*STORE_DEPTH+1, and ST_IDLE is reached one cycle later.
- Outputs depend only on registered state and registers; there is no combinational path from input to output. mem_address and sdram_wr_addr keep their last values outside the active states.
- SDRAM address = SDRAM_BASE + zero-extended idx, modulo 2**SDRAM_ADDR_W (wraps silently).
- STORE_DEPTH = 2**ADDR_W: idx ends at all-ones and never overflows. word_count is one bit wider so it can reach STORE_DEPTH.
- start asserted in any state other than ST_IDLE is ignored, including ST_DONE. start held high continuously re-triggers a pass on the cycle after ST_DONE returns to ST_IDLE.
- sdram_wr_ack outside ST_WR is ignored and has no effect.
- mem_dout outside ST_CAP is ignored.

Decomposition:
- Shared package ne_pkg holds:
  - typedef store_state_t (3-bit enum with the five states above)
  - DATA_W and SDRAM_ADDR_W default constants, shared with the load controller and the SDRAM controller
- No sub-module: a single FSM, an idx counter and a data register.

Test Plan:
1. STORE_DEPTH=4, SDRAM_BASE=24'h100, mem[i]=16'hA000+i, ack tied high. Pulse start -> writes (100,A000),(101,A001),(102,A002),(103,A003), each exactly 3 cycles apart. store_done is one cycle wide, 13 cycles after start is sampled. word_count=4; busy low afterwards.
2. Ack delayed 5 cycles on word 1 -> sdram_wr_req, addr and din are held constant for 6 cycles. No duplicate or skipped write occurs; final word_count=4.
3. start pulsed during ST_WR, then again in ST_DONE -> ignored; exactly STORE_DEPTH writes occur. A start after ST_IDLE is reached runs a second full pass, and word_count restarts from 0.
4. Reset asserted mid-pass while sdram_wr_req=1 -> all outputs go to 0 asynchronously, before the next clock edge. After release, a new start stores from idx 0.
5. SDRAM_BASE=24'hFFFFFE, STORE_DEPTH=4 -> write addresses FFFFFE, FFFFFF, 000000, 000001.
6. ADDR_W=2, STORE_DEPTH=4 (full range) -> mem_address runs 0..3, done fires once, word_count=4 with no counter overflow.
